cipher_framer: RTL and testbench

Downstream stage of the RC4 encryptor. It accepts the ciphertext byte stream (one byte per `in_valid` pulse, with no backpressure upstream) into an internal FIFO. It wraps the bytes into frames `SYNC, LEN, payload[LEN], CSUM` and presents them byte by byte on a valid/ready port to the link transmitter.

---
 rtl/cipher_framer_if.sv | 22 ++
 rtl/cipher_framer.sv | 163 ++++++++++++++++
 tb/tb_cipher_framer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cipher_framer_if.sv
// Byte-stream bundle for cipher_framer: ciphertext in, framed bytes out on valid/ready.
// The master modport is the framer's view; the slave modport is the surrounding logic's view.
interface cipher_framer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       flush;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       overflow;
  logic       busy;

  modport master (
    input  in_data, in_valid, flush, tx_ready,
    output tx_data, tx_valid, overflow, busy
  );

  modport slave (
    output in_data, in_valid, flush, tx_ready,
    input  tx_data, tx_valid, overflow, busy
  );
endinterface

// File: rtl/cipher_framer.sv
// Buffers RC4 ciphertext bytes in a FIFO and emits SYNC, LEN, payload, CSUM frames
// on a valid/ready byte port. All outputs are registered.
module cipher_framer #(
  parameter int         PAYLOAD_LEN = 16,
  parameter int         DEPTH       = 32,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic            clk,
  input  logic            rst,
  cipher_framer_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] PLEN_C  = CW'(PAYLOAD_LEN);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_LEN, S_PAYLOAD, S_CSUM} state_t;

  state_t        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    csum_q, csum_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;
  logic          flush_q, flush_d;
  logic [7:0]    mem_q [DEPTH];

  logic          hs;
  logic          push;
  logic          pop;
  logic          start;
  logic [7:0]    head;
  logic [7:0]    next_head;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    overflow_d = overflow_q;
    start      = 1'b0;

    hs        = tx_valid_q && bus.tx_ready;
    push      = bus.in_valid && (count_q != DEPTH_C);
    pop       = (state_q == S_PAYLOAD) && hs;
    head      = mem_q[rd_ptr_q];
    next_head = mem_q[rd_ptr_q + AW'(1)];

    // Flush is registered so it lines up with the count it will frame; outside IDLE it is dropped.
    flush_d = bus.flush && (state_q == S_IDLE);

    if (bus.in_valid && (count_q == DEPTH_C)) overflow_d = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    case (state_q)
      S_IDLE: begin
        if (count_q >= PLEN_C) begin
          len_d = 8'(PAYLOAD_LEN);
          start = 1'b1;
        end else if (flush_q && (count_q != '0)) begin
          len_d = 8'(count_q);
          start = 1'b1;
        end
        if (start) begin
          state_d    = S_SYNC;
          tx_valid_d = 1'b1;
          tx_data_d  = SYNC_BYTE;
          busy_d     = 1'b1;
        end
      end
      S_SYNC: begin
        if (hs) begin
          state_d   = S_LEN;
          tx_data_d = len_q;
        end
      end
      S_LEN: begin
        if (hs) begin
          state_d    = S_PAYLOAD;
          byte_cnt_d = 8'd0;
          csum_d     = 8'd0;
          tx_data_d  = head;
        end
      end
      S_PAYLOAD: begin
        if (hs) begin
          csum_d     = csum_q + head;
          byte_cnt_d = byte_cnt_q + 8'd1;
          // The following byte is already resident: the frame only starts once count >= len.
          if (byte_cnt_q == len_q - 8'd1) begin
            state_d   = S_CSUM;
            tx_data_d = csum_q + head;
          end else begin
            tx_data_d = next_head;
          end
        end
      end
      S_CSUM: begin
        if (hs) begin
          state_d    = S_IDLE;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= 8'd0;
      byte_cnt_q <= 8'd0;
      csum_q     <= 8'd0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      flush_q    <= flush_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_cipher_framer.sv
// Randomized bench for cipher_framer: a queue-based frame model predicts the byte stream,
// a negedge monitor captures handshaked bytes and checks output stability under stalls.
module tb_cipher_framer;

  localparam int         PLEN  = 16;
  localparam int         DEPTH = 32;
  localparam logic [7:0] SYNC  = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cipher_framer_if bus ();

  cipher_framer #(.PAYLOAD_LEN(PLEN), .DEPTH(DEPTH), .SYNC_BYTE(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit bp_en = 1'b0;

  logic [7:0] exp_q  [$];
  logic [7:0] got_q  [$];
  logic [7:0] pend_q [$];

  // Model: accepted bytes accumulate; a full frame forms at PLEN bytes, a flush frames the rest.
  function automatic void model_frame();
    int n;
    logic [7:0] s;
    logic [7:0] b;
    n = pend_q.size();
    s = 8'd0;
    exp_q.push_back(SYNC);
    exp_q.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      b = pend_q.pop_front();
      s = s + b;
      exp_q.push_back(b);
    end
    exp_q.push_back(s);
  endfunction

  function automatic void model_push(input logic [7:0] b);
    pend_q.push_back(b);
    if (pend_q.size() == PLEN) model_frame();
  endfunction

  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'd0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          total++;
          if (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data) begin
            bad++;
            $display("[TB] FAIL stall_hold: tx_valid=%b tx_data=%h, required tx_valid=1 tx_data=%h",
                     bus.tx_valid, bus.tx_data, prev_data);
          end
        end
        if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) got_q.push_back(bus.tx_data);
        prev_stall = (bus.tx_valid === 1'b1) && (bus.tx_ready === 1'b0);
        prev_data  = bus.tx_data;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) bus.tx_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accept);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    if (accept) model_push(b);
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    if (pend_q.size() > 0) model_frame();
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    bus.flush    = 1'b0;
    bus.tx_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
    pend_q.delete();
  endtask

  task automatic wait_idle(input string name);
    int quiet;
    int n;
    quiet = 0;
    n     = 0;
    while (quiet < 3 && n < 3000) begin
      tick();
      n++;
      if (bus.busy === 1'b1) quiet = 0;
      else quiet++;
    end
    if (quiet < 3) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: busy still %b after %0d cycles, required 0", name, bus.busy, n);
    end
  endtask

  task automatic check_stream(input string name);
    int n;
    wait_idle(name);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("[TB] FAIL %s_len: got %0d bytes, required %0d", name, got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL %s_byte%0d: got %h, required %h", name, i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    total += 4;
    if (bus.tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tx_valid: got %b, required 0", bus.tx_valid); end
    if (bus.tx_data !== 8'd0)  begin bad++; $display("[TB] FAIL reset_tx_data: got %h, required 00", bus.tx_data); end
    if (bus.overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow: got %b, required 0", bus.overflow); end
    if (bus.busy !== 1'b0)     begin bad++; $display("[TB] FAIL reset_busy: got %b, required 0", bus.busy); end
  endtask

  task automatic test_full_frame();
    int busy_cycles;
    int n;
    for (int b = 1; b <= 16; b++) push_byte(8'(b), 1'b1);
    total++;
    if (bus.tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL full_sync_early: tx_valid=%b, required 0", bus.tx_valid); end
    tick();
    total += 3;
    if (bus.tx_valid !== 1'b1) begin bad++; $display("[TB] FAIL full_sync_valid: got %b, required 1", bus.tx_valid); end
    if (bus.tx_data !== SYNC)  begin bad++; $display("[TB] FAIL full_sync_data: got %h, required %h", bus.tx_data, SYNC); end
    if (bus.busy !== 1'b1)     begin bad++; $display("[TB] FAIL full_busy_rise: got %b, required 1", bus.busy); end
    busy_cycles = 1;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      tick();
      n++;
      if (bus.busy === 1'b1) busy_cycles++;
    end
    total++;
    if (busy_cycles != PLEN + 3) begin bad++; $display("[TB] FAIL full_busy_cycles: got %0d, required %0d", busy_cycles, PLEN + 3); end
    total++;
    if (got_q.size() == 0 || got_q[got_q.size()-1] !== 8'h88) begin
      bad++;
      $display("[TB] FAIL full_csum: got %h, required 88", (got_q.size() > 0) ? got_q[got_q.size()-1] : 8'hxx);
    end
    check_stream("full");
  endtask

  task automatic test_flush();
    bit seen_busy;
    push_byte(8'h10, 1'b1);
    push_byte(8'h20, 1'b1);
    push_byte(8'h30, 1'b1);
    pulse_flush();
    total++;
    if (bus.tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_early: tx_valid=%b, required 0", bus.tx_valid); end
    tick();
    total++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== SYNC) begin
      bad++;
      $display("[TB] FAIL flush_sync: tx_valid=%b tx_data=%h, required 1 %h", bus.tx_valid, bus.tx_data, SYNC);
    end
    check_stream("flush");
    pulse_flush();
    seen_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.busy !== 1'b0) seen_busy = 1'b1;
    end
    total += 2;
    if (seen_busy) begin bad++; $display("[TB] FAIL empty_flush_busy: got 1, required 0"); end
    if (got_q.size() != 0) begin bad++; $display("[TB] FAIL empty_flush_bytes: got %0d bytes, required 0", got_q.size()); end
  endtask

  task automatic test_backpressure();
    bp_en = 1'b1;
    for (int b = 1; b <= 16; b++) push_byte(8'(b), 1'b1);
    check_stream("backpressure");
    bp_en = 1'b0;
    tick();
    bus.tx_ready = 1'b1;
  endtask

  task automatic test_random();
    int n;
    bp_en = 1'b1;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        push_byte(8'($urandom_range(0, 255)), 1'b1);
        repeat ($urandom_range(0, 2)) tick();
      end
      wait_idle("random_pre");
      pulse_flush();
      check_stream("random");
    end
    bp_en = 1'b0;
    tick();
    bus.tx_ready = 1'b1;
  endtask

  task automatic test_overflow();
    do_reset();
    bus.tx_ready = 1'b0;
    for (int b = 1; b <= DEPTH + 1; b++) begin
      push_byte(8'(b), b <= DEPTH);
      if (b == DEPTH) begin
        total++;
        if (bus.overflow !== 1'b0) begin bad++; $display("[TB] FAIL overflow_early: got %b, required 0", bus.overflow); end
      end
    end
    total++;
    if (bus.overflow !== 1'b1) begin bad++; $display("[TB] FAIL overflow_set: got %b, required 1", bus.overflow); end
    bus.tx_ready = 1'b1;
    check_stream("overflow");
    total++;
    if (bus.overflow !== 1'b1) begin bad++; $display("[TB] FAIL overflow_sticky: got %b, required 1", bus.overflow); end
  endtask

  task automatic test_csum_wrap();
    do_reset();
    for (int i = 0; i < PLEN; i++) push_byte(8'hFF, 1'b1);
    wait_idle("csum_wrap");
    total++;
    if (got_q.size() == 0 || got_q[got_q.size()-1] !== 8'hF0) begin
      bad++;
      $display("[TB] FAIL csum_wrap: got %h, required f0", (got_q.size() > 0) ? got_q[got_q.size()-1] : 8'hxx);
    end
    check_stream("csum_wrap");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < PLEN + 4; i++) push_byte(8'($urandom_range(0, 255)), 1'b1);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL midreset_busy_before: got %b, required 1", bus.busy); end
    rst = 1'b1;
    tick();
    total += 4;
    if (bus.tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_tx_valid: got %b, required 0", bus.tx_valid); end
    if (bus.busy !== 1'b0)     begin bad++; $display("[TB] FAIL midreset_busy: got %b, required 0", bus.busy); end
    if (bus.overflow !== 1'b0) begin bad++; $display("[TB] FAIL midreset_overflow: got %b, required 0", bus.overflow); end
    if (bus.tx_data !== 8'd0)  begin bad++; $display("[TB] FAIL midreset_tx_data: got %h, required 00", bus.tx_data); end
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
    pend_q.delete();
    for (int i = 0; i < PLEN; i++) push_byte(8'($urandom_range(0, 255)), 1'b1);
    check_stream("after_reset");
  endtask

  initial begin
    $display("[TB] cipher_framer bench start");
    test_reset();
    test_full_frame();
    test_flush();
    test_backpressure();
    test_random();
    test_overflow();
    test_csum_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
